// File: rtl/wave_freq_meter_if.sv
// Waveform sample input and frequency-measurement outputs of wave_freq_meter.
interface wave_freq_meter_if;
  logic signed [15:0] sample;
  logic        [31:0] ctrl_out;
  logic               valid;
  logic               timeout;

  modport master (output sample, input ctrl_out, valid, timeout);
  modport slave  (input sample, output ctrl_out, valid, timeout);
endinterface

// File: rtl/wave_freq_meter.sv
// Measures the period between negative-to-non-negative crossings of a sampled
// waveform and converts it into a frequency control word floor(2^32 / P).
module wave_freq_meter #(
  parameter logic [31:0] TIMEOUT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  wave_freq_meter_if.slave bus
);

  localparam logic [0:0] ARM     = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;
  localparam logic [5:0] LAST_STEP = 6'd33;

  logic signed [15:0] prev_sample;
  logic [0:0]         state;
  logic [31:0]        count;
  logic               timeout_r;
  logic               crossing;
  logic               start;

  logic               busy;
  logic [5:0]         step;
  logic [31:0]        divisor;
  logic [31:0]        rem;
  logic [31:0]        quot;
  logic [31:0]        ctrl_r;
  logic               valid_r;
  logic [32:0]        step_res;

  // One restoring-division step: returns {quotient bit, new remainder}.
  function automatic logic [32:0] div_step(input logic [31:0] r,
                                           input logic        bit_in,
                                           input logic [31:0] d);
    logic [32:0] trial;
    logic [32:0] diff;
    trial = {r, bit_in};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d}) div_step = {1'b1, diff[31:0]};
    else                    div_step = {1'b0, trial[31:0]};
  endfunction

  assign crossing = prev_sample[15] & ~bus.sample[15];
  assign start    = (state == MEASURE) && crossing && !busy;
  // The 33-bit dividend 2^32 contributes a single 1 on the first step only.
  assign step_res = div_step(rem, step == 6'd0, divisor);

  // Period measurement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sample <= '0;
      state       <= ARM;
      count       <= '0;
      timeout_r   <= 1'b0;
    end else begin
      prev_sample <= bus.sample;
      timeout_r   <= 1'b0;
      case (state)
        ARM: begin
          if (crossing) begin
            count <= 32'd1;
            state <= MEASURE;
          end
        end
        default: begin
          if (crossing) begin
            count <= 32'd1;
          end else if (count == TIMEOUT) begin
            timeout_r <= 1'b1;
            count     <= '0;
            state     <= ARM;
          end else begin
            count <= count + 32'd1;
          end
        end
      endcase
    end
  end

  // Sequential divider: 33 iterations, then the result is published
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      step    <= '0;
      divisor <= '0;
      rem     <= '0;
      quot    <= '0;
      ctrl_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        step    <= '0;
        divisor <= count;
        rem     <= '0;
        quot    <= '0;
      end else if (busy) begin
        if (step == LAST_STEP) begin
          ctrl_r  <= quot;
          valid_r <= 1'b1;
          busy    <= 1'b0;
        end else begin
          rem  <= step_res[31:0];
          quot <= {quot[30:0], step_res[32]};
          step <= step + 6'd1;
        end
      end
    end
  end

  assign bus.ctrl_out = ctrl_r;
  assign bus.valid    = valid_r;
  assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_wave_freq_meter.sv
// Directed bench for wave_freq_meter: default-TIMEOUT instance (a) and a
// TIMEOUT=100 instance (b), both fed the same waveform.
module tb_wave_freq_meter;

  logic clk;
  logic rst;

  wave_freq_meter_if bus_a ();
  wave_freq_meter_if bus_b ();

  wave_freq_meter dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  wave_freq_meter #(.TIMEOUT(32'd100)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int          vq[$];
  int          tq[$];
  logic [31:0] cq[$];
  logic [31:0] probe_val;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] stim(input int mode, input int e);
    logic [31:0] ph;
    case (mode)
      0: begin
        ph = 32'(e - 1) << 24;
        stim = {~ph[31], ph[30:16]};
      end
      1: stim = (e % 2 == 1) ? 16'h8000 : 16'h7FFF;
      2: stim = (e % 3 == 0) ? 16'h0001 : 16'h8000;
      3: stim = 16'h0000;
      4: stim = (e == 1 || e == 151 || (e >= 153 && e <= 159)) ? 16'h8000 : 16'h1234;
      5: stim = (e == 1 || e == 101) ? 16'h8000 : 16'h1234;
      default: stim = (e == 61 || e == 65) ? 16'h8000 : 16'h1234;
    endcase
  endfunction

  // Drives n edges of waveform `mode`; logs valid/timeout edges of the selected instance.
  task automatic run(input int mode, input int n, input bit sel_b, input int probe_e);
    logic v, t;
    logic [31:0] c;
    vq.delete(); tq.delete(); cq.delete();
    probe_val = 32'hDEAD_BEEF;
    for (int e = 1; e <= n; e++) begin
      bus_a.sample = stim(mode, e);
      bus_b.sample = stim(mode, e);
      @(posedge clk); #1;
      v = sel_b ? bus_b.valid    : bus_a.valid;
      t = sel_b ? bus_b.timeout  : bus_a.timeout;
      c = sel_b ? bus_b.ctrl_out : bus_a.ctrl_out;
      if (v) begin vq.push_back(e); cq.push_back(c); end
      if (t) tq.push_back(e);
      if (e == probe_e) probe_val = c;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.sample = '0;
    bus_b.sample = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int qi(input int idx);
    qi = (vq.size() > idx) ? vq[idx] : -1;
  endfunction

  function automatic logic [31:0] qc(input int idx);
    qc = (cq.size() > idx) ? cq[idx] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk = 1'b0;
    rst = 1'b0;
    bus_a.sample = '0;
    bus_b.sample = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_eq("rst_ctrl_a",    bus_a.ctrl_out, 0);
    expect_eq("rst_valid_a",   bus_a.valid,    0);
    expect_eq("rst_timeout_a", bus_a.timeout,  0);
    expect_eq("rst_ctrl_b",    bus_b.ctrl_out, 0);
    expect_eq("rst_valid_b",   bus_b.valid,    0);
    expect_eq("rst_timeout_b", bus_b.timeout,  0);
    rst = 1'b0;

    // Sawtooth, P=256: crossings at 129, 385, 641
    run(0, 700, 1'b0, 418);
    expect_eq("saw_nvalid",   vq.size(), 2);
    expect_eq("saw_v0_edge",  qi(0), 419);
    expect_eq("saw_v0_ctrl",  qc(0), 32'h0100_0000);
    expect_eq("saw_v1_edge",  qi(1), 675);
    expect_eq("saw_v1_ctrl",  qc(1), 32'h0100_0000);
    expect_eq("saw_pre_ctrl", probe_val, 0);
    expect_eq("saw_ntimeout", tq.size(), 0);

    // Alternating, P=2: starts at 4, 40, 76
    do_reset();
    run(1, 120, 1'b0, 60);
    expect_eq("alt_nvalid",  vq.size(), 3);
    expect_eq("alt_v0_edge", qi(0), 38);
    expect_eq("alt_v1_edge", qi(1), 74);
    expect_eq("alt_v2_edge", qi(2), 110);
    expect_eq("alt_v0_ctrl", qc(0), 32'h8000_0000);
    expect_eq("alt_v2_ctrl", qc(2), 32'h8000_0000);
    expect_eq("alt_hold",    probe_val, 32'h8000_0000);

    // Pattern P=3: starts at 6, 42
    do_reset();
    run(2, 80, 1'b0, 0);
    expect_eq("p3_nvalid",  vq.size(), 2);
    expect_eq("p3_v0_edge", qi(0), 40);
    expect_eq("p3_v1_edge", qi(1), 76);
    expect_eq("p3_v0_ctrl", qc(0), 32'h5555_5555);

    // Constant zero: nothing ever happens
    do_reset();
    run(3, 10000, 1'b0, 10000);
    expect_eq("const_nvalid",   vq.size(), 0);
    expect_eq("const_ntimeout", tq.size(), 0);
    expect_eq("const_ctrl",     probe_val, 0);

    // TIMEOUT=100: crossing at 2, timeout at 102, then P=8 from crossings 152/160
    do_reset();
    run(4, 200, 1'b1, 150);
    expect_eq("to_ntimeout",  tq.size(), 1);
    expect_eq("to_t0_edge",   (tq.size() > 0) ? tq[0] : -1, 102);
    expect_eq("to_pre_ctrl",  probe_val, 0);
    expect_eq("to_nvalid",    vq.size(), 1);
    expect_eq("to_v0_edge",   qi(0), 194);
    expect_eq("to_v0_ctrl",   qc(0), 32'h2000_0000);

    // Crossing coincides with count==TIMEOUT: crossing wins, P=100
    do_reset();
    run(5, 140, 1'b1, 0);
    expect_eq("coin_ntimeout", tq.size(), 0);
    expect_eq("coin_nvalid",   vq.size(), 1);
    expect_eq("coin_v0_edge",  qi(0), 136);
    expect_eq("coin_v0_ctrl",  qc(0), 32'h028F_5C28);

    // Reset 10 clocks after a divider start aborts the division
    do_reset();
    run(1, 14, 1'b0, 0);
    expect_eq("abort_pre_nvalid", vq.size(), 0);
    rst = 1'b1;
    bus_a.sample = '0;
    bus_b.sample = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("abort_rst_ctrl",  bus_a.ctrl_out, 0);
    expect_eq("abort_rst_valid", bus_a.valid, 0);
    rst = 1'b0;
    run(6, 110, 1'b0, 99);
    expect_eq("abort_post_ctrl", probe_val, 0);
    expect_eq("abort_nvalid",    vq.size(), 1);
    expect_eq("abort_v0_edge",   qi(0), 100);
    expect_eq("abort_v0_ctrl",   qc(0), 32'h4000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_freq_meter.md
WAVE_FREQ_METER -- requirements
Module: wave_freq_meter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 32'hFFFF_FFFF, the maximum period in clocks; legal range 3..2^32-1.
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port sample  input  16  signed two's-complement waveform sample, sampled every clk.
REQ-005 Port ctrl_out  output  32  measured frequency control word, frequency = clk * ctrl_out / 2^32.
REQ-006 Port valid  output  1  one-cycle pulse: ctrl_out has just been updated.
REQ-007 Port timeout  output  1  one-cycle pulse: a period was abandoned because it reached TIMEOUT.

Function
REQ-008 The block SHALL register sample into prev_sample every clk.
REQ-009 A crossing event SHALL occur at edge k when prev_sample[15]=1 and sample[15]=0 (negative to non-negative).
REQ-010 The FSM SHALL have two states, ARM and MEASURE; the reset state SHALL be ARM.
REQ-011 In ARM, a crossing SHALL set count to 1 and move to MEASURE; ARM SHALL produce no valid and no timeout.
REQ-012 In MEASURE with no crossing, count SHALL increment by 1 per clk.
REQ-013 In MEASURE, if count equals TIMEOUT with no crossing, timeout SHALL pulse, count SHALL clear to 0, and the FSM SHALL return to ARM.
REQ-014 In MEASURE, a crossing SHALL set count to 1, so that period P equals the number of clocks between consecutive crossings, with P >= 2.
REQ-015 On that crossing, if the divider is idle, the block SHALL latch P as divisor and start the divider.
REQ-016 A crossing while the divider is busy SHALL restart count but discard its period; the in-flight division SHALL be unaffected.
REQ-017 The divider SHALL be a sequential restoring divider computing floor(2^32 / P): 33-bit dividend 2^32, one quotient bit per clk, 33 iterations, low 32 quotient bits kept.
REQ-018 For a crossing at edge k that starts the divider, ctrl_out SHALL update and valid SHALL pulse at edge k+34.
REQ-019 The divider SHALL report busy from edge k+1 through edge k+34 inclusive, and SHALL accept a new start at edge k+35 or later.
REQ-020 The result SHALL satisfy P=2 -> 0x8000_0000 and P=TIMEOUT(default) -> 0x0000_0001.
REQ-021 ctrl_out SHALL hold its last value between valid pulses.
REQ-022 When a crossing and the TIMEOUT condition occur at the same edge, the crossing SHALL win and timeout SHALL NOT pulse.
REQ-023 valid and timeout SHALL never pulse at the same edge as each other unless both conditions independently occur there.

Reset
REQ-024 While rst=1, the block SHALL hold: ctrl_out=0, valid=0, timeout=0, prev_sample=0x0000, count=0, divider idle, state ARM.
REQ-025 Reset asserted mid-division SHALL abort the division with no valid pulse; ctrl_out SHALL stay 0.
REQ-026 After rst deasserts, two crossings SHALL be required before the first valid.

Verification
REQ-027 Drive a sawtooth {~phase[31],phase[30:16]} with phase += 0x0100_0000 per clk -> valid 34 clocks after the second crossing, ctrl_out=0x0100_0000; each later accepted period also gives 0x0100_0000.
REQ-028 Drive samples alternating 0x8000/0x7FFF every clk (P=2) -> ctrl_out=0x8000_0000; periods ending while the divider is busy are dropped; valid spacing >= 35 clocks.
REQ-029 Drive the repeating pattern 0x8000,0x8000,0x0001 (P=3) -> ctrl_out=0x5555_5555.
REQ-030 Hold sample constant 0x0000 for 10000 clocks after reset -> valid and timeout never assert; ctrl_out=0.
REQ-031 Set TIMEOUT=100, give one crossing, then hold sample at 0x1234 -> timeout pulses once, 100 clocks after the crossing; the block is then in ARM; the next two crossings spaced 8 clocks apart give ctrl_out=0x2000_0000.
REQ-032 Assert rst 10 clocks after a divider start -> no valid; ctrl_out=0 and state ARM after release.
